// File: rtl/parallel_rx_pixel.sv
// Four-phase valid/ack byte receiver pairing bytes into tagged RGB565 pixels; ack and pixel load one cycle after synced valid.
// Backpressure: a new byte is not acked while a pixel is pending and not accepted. Optional resync timeout: PRX_TIMEOUT_EN.
module parallel_rx_pixel #(
    parameter int H_PIX          = 160,
    parameter int V_PIX          = 120,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     clk,
    input  logic                     reset_p,
    input  logic                     valid,
    input  logic [7:0]               d_in,
    output logic                     ack,
    output logic [15:0]              pix_data,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [$clog2(H_PIX)-1:0] pix_x,
    output logic [$clog2(V_PIX)-1:0] pix_y,
    output logic                     sof,
    output logic                     eol,
    output logic                     eof,
    output logic [15:0]              frame_cnt,
    output logic                     resync
);
    localparam int XW = $clog2(H_PIX);
    localparam int YW = $clog2(V_PIX);

    typedef enum logic {S_IDLE, S_WAIT_LOW} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   valid_s;
    logic                   accept;
    logic                   phase_lo_q;
    logic [7:0]             hi_q;
    logic [XW-1:0]          x_q;
    logic [YW-1:0]          y_q;
    logic                   last_x, last_y;
    logic                   tmo_hit;
    logic [15:0]            pix_data_q;
    logic                   pix_valid_q;
    logic [XW-1:0]          pix_x_q;
    logic [YW-1:0]          pix_y_q;
    logic                   sof_q, eol_q, eof_q;
    logic [15:0]            frame_cnt_q;

    always_ff @(posedge clk) begin
        if (reset_p) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], valid};
    end
    assign valid_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset_p) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept)   state_d = S_WAIT_LOW;
            S_WAIT_LOW: if (!valid_s) state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // A byte is taken only when the output register is free or draining this cycle.
    always_comb begin
        ack    = (state_q == S_WAIT_LOW);
        accept = (state_q == S_IDLE) && valid_s && (!pix_valid_q || pix_ready);
    end

    assign last_x = (x_q == XW'(H_PIX - 1));
    assign last_y = (y_q == YW'(V_PIX - 1));

`ifdef PRX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          tmo_run;
    logic          resync_q;

    // Only a partially received pixel or frame can stall; a clean (0,0)/HIGH position never times out.
    assign tmo_run = (state_q == S_IDLE) && (phase_lo_q || (x_q != '0) || (y_q != '0));
    assign tmo_hit = tmo_run && !accept && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset_p) begin
            tmo_q    <= '0;
            resync_q <= 1'b0;
        end else begin
            resync_q <= tmo_hit;
            if (accept || tmo_hit) tmo_q <= '0;
            else if (tmo_run)      tmo_q <= tmo_q + TW'(1);
        end
    end
    assign resync = resync_q;
`else
    // Constant 0 for any positive timeout: no counter exists in this build.
    assign tmo_hit = (TIMEOUT_CYCLES < 1);
    assign resync  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset_p) begin
            phase_lo_q  <= 1'b0;
            hi_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (pix_valid_q && pix_ready) pix_valid_q <= 1'b0;
            if (accept && !phase_lo_q) begin
                hi_q       <= d_in;
                phase_lo_q <= 1'b1;
            end else if (accept) begin
                phase_lo_q  <= 1'b0;
                pix_data_q  <= {hi_q, d_in};
                pix_valid_q <= 1'b1;
                pix_x_q     <= x_q;
                pix_y_q     <= y_q;
                sof_q       <= (x_q == '0) && (y_q == '0);
                eol_q       <= last_x;
                eof_q       <= last_x && last_y;
                if (!last_x) begin
                    x_q <= x_q + XW'(1);
                end else begin
                    x_q <= '0;
                    if (last_y) begin
                        y_q         <= '0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end else begin
                        y_q <= y_q + YW'(1);
                    end
                end
            end else if (tmo_hit) begin
                phase_lo_q <= 1'b0;
                x_q        <= '0;
                y_q        <= '0;
            end
        end
    end

    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign sof       = sof_q;
    assign eol       = eol_q;
    assign eof       = eof_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_parallel_rx_pixel.sv
// Bench for parallel_rx_pixel: random bytes over the four-phase link, pixels scored against a frame-position model.
module tb_parallel_rx_pixel;
    localparam int H   = 6;
    localparam int V   = 3;
    localparam int SS  = 2;
    localparam int TMO = 100;
    localparam int FR  = H * V;

    logic        clk = 1'b0;
    logic        reset_p, valid, ack, pix_valid, pix_ready;
    logic [7:0]  d_in;
    logic [15:0] pix_data, frame_cnt;
    logic [2:0]  pix_x;
    logic [1:0]  pix_y;
    logic        sof, eol, eof, resync;

    parallel_rx_pixel #(.H_PIX(H), .V_PIX(V), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_p(reset_p), .valid(valid), .d_in(d_in), .ack(ack),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .sof(sof), .eol(eol), .eof(eof),
        .frame_cnt(frame_cnt), .resync(resync));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        int          x;
        int          y;
        logic        sof, eol, eof;
        logic [15:0] fc;
    } pix_t;

    pix_t        exp_q[$];
    int          checks = 0, errors = 0;
    int          eol_seen = 0, eof_seen = 0;
    int          rdy_mode = 1;
    bit          m_low, last_low;
    logic [7:0]  m_hi;
    int          m_pos;
    logic [15:0] m_frames;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired, event not seen", name);
    endtask

    // Reference: pixel k of a frame sits at (k mod H, k div H); frames counted on the eof pixel.
    task automatic model_push(input logic [7:0] b);
        pix_t p;
        if (!m_low) begin
            m_hi = b; m_low = 1; last_low = 0;
        end else begin
            p.d = {m_hi, b};
            p.x = m_pos % H;
            p.y = m_pos / H;
            p.sof = (m_pos == 0);
            p.eol = (p.x == H - 1);
            p.eof = (m_pos == FR - 1);
            if (p.eof) begin m_frames++; m_pos = 0; end
            else m_pos++;
            p.fc = m_frames;
            exp_q.push_back(p);
            m_low = 0; last_low = 1;
        end
    endtask

    task automatic model_reset();
        m_low = 0; m_pos = 0; m_frames = 0;
    endtask

    task automatic wait_ack(input logic lvl, input string name, output int n);
        n = 0;
        while (ack !== lvl && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        if (ack !== lvl) fail(name);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input bit chk_lat);
        int n, bad;
        model_push(b);
        @(posedge clk); #1;
        d_in = b; valid = 1;
        wait_ack(1'b1, "ack_rise_timeout", n);
        if (chk_lat) check("ack_rise_latency", n, SS + 1);
        if (last_low) check("pix_valid_with_ack", pix_valid, 1);
        bad = 0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!ack) bad++;
        end
        if (hold > 0) check("ack_held_while_valid", bad, 0);
        valid = 0; d_in = 8'($urandom);
        wait_ack(1'b0, "ack_fall_timeout", n);
        check("ack_fall_within_bound", (n <= SS + 1), 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        rdy_mode = 1;
        while ((exp_q.size() != 0 || pix_valid) && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        if (exp_q.size() != 0 || pix_valid) fail("drain_timeout");
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; reset_p = 1;
        @(posedge clk); #1; reset_p = 0; valid = 0;
        model_reset();
    endtask

    initial begin
        pix_ready = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       pix_ready = 0;
                1:       pix_ready = 1;
                default: pix_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Scoreboard: every handshake pops the model; a stalled pixel must stay frozen.
    initial begin
        pix_t e, h;
        bit   hold;
        hold = 0;
        forever begin
            @(negedge clk);
            if (reset_p) begin
                hold = 0;
            end else begin
`ifndef PRX_TIMEOUT_EN
                check("resync_tied_low", resync, 0);
`endif
                if (hold) begin
                    check("hold_valid", pix_valid, 1);
                    check("hold_data", pix_data, h.d);
                    check("hold_xy", {pix_x, pix_y}, {h.x[2:0], h.y[1:0]});
                    check("hold_flags", {sof, eol, eof}, {h.sof, h.eol, h.eof});
                end
                if (pix_valid && pix_ready) begin
                    if (exp_q.size() == 0) begin
                        fail("unexpected_pixel");
                    end else begin
                        e = exp_q.pop_front();
                        check("px_data", pix_data, e.d);
                        check("px_x", pix_x, e.x);
                        check("px_y", pix_y, e.y);
                        check("px_sof", sof, e.sof);
                        check("px_eol", eol, e.eol);
                        check("px_eof", eof, e.eof);
                        check("px_frame_cnt", frame_cnt, e.fc);
                        if (eol) eol_seen++;
                        if (eof) eof_seen++;
                    end
                end
                hold = pix_valid && !pix_ready;
                if (hold) begin
                    h.d = pix_data; h.x = pix_x; h.y = pix_y;
                    h.sof = sof; h.eol = eol; h.eof = eof;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad, pulses;
        reset_p = 1; valid = 0; d_in = 0; rdy_mode = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_p = 0;
        check("rst_ack", ack, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_xy", {pix_x, pix_y}, 0);
        check("rst_flags", {sof, eol, eof}, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_resync", resync, 0);

        // First pixel: literal expectations
        send_byte(8'hF8, 0, 1);
        send_byte(8'h00, 0, 1);
        check("t1_data", pix_data, 16'hF800);
        check("t1_xy", {pix_x, pix_y}, 0);
        check("t1_flags", {sof, eol, eof}, 3'b100);
        wait_drain();

        // Two full frames plus one pixel
        pulse_reset();
        eol_seen = 0; eof_seen = 0;
        for (int i = 0; i < 4 * FR + 2; i++) send_byte(8'($urandom), 0, 1);
        wait_drain();
        check("t2_eol_count", eol_seen, 2 * V);
        check("t2_eof_count", eof_seen, 2);
        check("t2_frame_cnt", frame_cnt, 2);
        check("t2_next_xy", {pix_x, pix_y}, 0);
        check("t2_next_sof", sof, 1);

        // Backpressure: pending pixel blocks the next ack
        rdy_mode = 0;
        send_byte(8'($urandom), 0, 0);
        send_byte(8'($urandom), 0, 0);
        d_in = 8'($urandom);
        model_push(d_in);
        @(posedge clk); #1;
        valid = 1;
        bad = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (ack) bad++;
        end
        check("t3_ack_blocked", bad, 0);
        check("t3_pix_pending", pix_valid, 1);
        rdy_mode = 1;
        wait_ack(1'b1, "t3_ack_after_ready", n);
        valid = 0;
        wait_ack(1'b0, "t3_ack_fall", n);
        rdy_mode = 2;
        for (int i = 0; i < 17; i++) send_byte(8'($urandom), $urandom_range(0, 3), 0);
        wait_drain();

        // Long valid: one byte only
        rdy_mode = 2;
        send_byte(8'h5A, 1000, 0);
        for (int i = 0; i < 40; i++) send_byte(8'($urandom), $urandom_range(0, 5), 0);
        wait_drain();

        // Reset mid-transfer with valid high
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0, 0);
        wait_drain();
        model_push(8'h77);
        @(posedge clk); #1;
        d_in = 8'h77; valid = 1;
        wait_ack(1'b1, "t5_ack_rise", n);
        pulse_reset();
        check("t5_ack", ack, 0);
        check("t5_pix_valid", pix_valid, 0);
        check("t5_xy", {pix_x, pix_y}, 0);
        check("t5_frame_cnt", frame_cnt, 0);
        send_byte(8'hAB, 0, 1);
        send_byte(8'hCD, 0, 1);
        check("t5_data", pix_data, 16'hABCD);
        check("t5_xy_after", {pix_x, pix_y}, 0);
        check("t5_sof", sof, 1);
        wait_drain();

`ifdef PRX_TIMEOUT_EN
        pulse_reset();
        send_byte(8'hAA, 0, 1);
        pulses = 0;
        repeat (TMO + 50) begin
            @(posedge clk); #1;
            if (resync) pulses++;
        end
        check("t6_resync_pulses", pulses, 1);
        m_low = 0; m_pos = 0;
        send_byte(8'h12, 0, 1);
        send_byte(8'h34, 0, 1);
        check("t6_data", pix_data, 16'h1234);
        check("t6_xy", {pix_x, pix_y}, 0);
        check("t6_sof", sof, 1);
        wait_drain();
`else
        pulses = 0;
        check("t6_no_timeout_build", pulses, 0);
`endif

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
